// File: rtl/fir_decimator.sv
// fir_decimator: keeps one of every DECIM FIR output samples, rounds and
// saturates each kept sample to OUT_W bits, and queues the results in a
// small FIFO with a registered first-word-fall-through head for a
// ready/valid consumer. The FIR cannot stall, so a full FIFO drops the
// sample and raises the sticky ovf flag.
//
// Optional feature: define FIR_DEC_SATCNT_EN to add the 16-bit sat_count
// output, a saturating count of saturated samples written to the FIFO.
module fir_decimator #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 12,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fir_en,
    input  logic [IN_W-1:0]  in_wave,
    input  logic             dec_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             sat_flag,
    output logic             ovf
`ifdef FIR_DEC_SATCNT_EN
    ,
    output logic [15:0]      sat_count
`endif
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = AW + 1;

    // Rounding constant and clamp limits, all at IN_W+1 bits so the
    // rounding add can never wrap.
    localparam logic signed [IN_W:0] HALF  = (IN_W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic [PH_W-1:0]      PH_LAST = PH_W'(DECIM - 1);
    localparam logic [CW-1:0]        FULL_LVL = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0] s1_data_q, s1_data_d;
    logic             s1_sat_q, s1_sat_d;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    mem_cnt_q, mem_cnt_d;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic             mem_sat  [DEPTH];

    // ------------------------------------------------------------------
    // Decimation and rounding datapath
    // ------------------------------------------------------------------
    logic                keep;
    logic signed [IN_W:0] in_ext;
    logic signed [IN_W:0] rnd_sum;
    logic signed [IN_W:0] rnd_shift;
    logic [OUT_W-1:0]    rnd_data;
    logic                rnd_sat;

    // Round half up, then clamp to the signed OUT_W range.
    always_comb begin
        keep      = fir_en && (phase_q == '0);
        in_ext    = {in_wave[IN_W-1], in_wave};
        rnd_sum   = in_ext + HALF;
        rnd_shift = rnd_sum >>> SHIFT;
        rnd_data  = rnd_shift[OUT_W-1:0];
        rnd_sat   = 1'b0;
        if (rnd_shift > MAX_V) begin
            rnd_data = MAX_V[OUT_W-1:0];
            rnd_sat  = 1'b1;
        end else if (rnd_shift < MIN_V) begin
            rnd_data = MIN_V[OUT_W-1:0];
            rnd_sat  = 1'b1;
        end
    end

    // Phase counter and stage-1 register next state; clear wins over input.
    always_comb begin
        phase_d    = phase_q;
        s1_valid_d = 1'b0;
        s1_data_d  = rnd_data;
        s1_sat_d   = rnd_sat;
        if (dec_clr) begin
            phase_d = '0;
        end else if (fir_en) begin
            phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            s1_valid_d = keep;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control. Occupancy counts the memory entries plus the head
    // register, so DEPTH samples fit in total.
    // ------------------------------------------------------------------
    logic [CW-1:0] level;
    logic          pop;
    logic          full;
    logic          push;
    logic          load;

    // Push/pop/head-load decisions and pointer, level and flag updates.
    always_comb begin
        level       = mem_cnt_q + CW'(out_valid_q);
        pop         = out_valid_q && out_ready && !dec_clr;
        full        = (level == FULL_LVL);
        push        = s1_valid_q && (!full || pop) && !dec_clr;
        load        = (!out_valid_q || pop) && (mem_cnt_q != '0) && !dec_clr;

        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(load);
        mem_cnt_d   = mem_cnt_q + CW'(push) - CW'(load);
        out_valid_d = load ? 1'b1 : (pop ? 1'b0 : out_valid_q);
        out_data_d  = load ? mem_data[rd_ptr_q] : out_data_q;
        sat_d       = load ? mem_sat[rd_ptr_q]  : sat_q;
        ovf_d       = ovf_q || (s1_valid_q && full && !pop);

        if (dec_clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_cnt_d   = '0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end
    end

    // FIFO storage: one write-enabled register per entry, no reset needed.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == AW'(gi))) begin
                    mem_data[gi] <= s1_data_q;
                    mem_sat[gi]  <= s1_sat_q;
                end
            end
        end
    endgenerate

    // All control and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sat_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sat_q    <= s1_sat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;
    assign ovf       = ovf_q;

`ifdef FIR_DEC_SATCNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Count saturated samples entering the FIFO, sticking at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (dec_clr) begin
            sat_cnt_d = '0;
        end else if (push && s1_sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator: dut0 uses the default DECIM=4,
// dut1 uses DECIM=1. Expected samples are queued as stimulus is issued;
// per-DUT monitors pop and compare on every accepted output.
module tb_fir_decimator;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        en0 = 1'b0, clr0 = 1'b0, rdy0 = 1'b0;
    logic [19:0] in0 = '0;
    logic        valid0, sat0, ovf0;
    logic [7:0]  data0;

    logic        en1 = 1'b0, clr1 = 1'b0, rdy1 = 1'b0;
    logic [19:0] in1 = '0;
    logic        valid1, sat1, ovf1;
    logic [7:0]  data1;

`ifdef FIR_DEC_SATCNT_EN
    logic [15:0] sc0, sc1;
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fir_decimator u_dut0 (
        .clk(clk), .rst_n(rst_n), .fir_en(en0), .in_wave(in0), .dec_clr(clr0),
        .out_valid(valid0), .out_ready(rdy0), .out_data(data0),
        .sat_flag(sat0), .ovf(ovf0)
`ifdef FIR_DEC_SATCNT_EN
        , .sat_count(sc0)
`endif
    );

    fir_decimator #(.DECIM(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .fir_en(en1), .in_wave(in1), .dec_clr(clr1),
        .out_valid(valid1), .out_ready(rdy1), .out_data(data1),
        .sat_flag(sat1), .ovf(ovf1)
`ifdef FIR_DEC_SATCNT_EN
        , .sat_count(sc1)
`endif
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Drive one cycle of dut0 input, then step past the next edge.
    task automatic cyc0(input logic en, input logic signed [19:0] v, input logic clr);
        en0 = en; in0 = v; clr0 = clr;
        @(posedge clk); #1;
        en0 = 1'b0; clr0 = 1'b0;
    endtask

    task automatic cyc1(input logic en, input logic signed [19:0] v, input logic clr);
        en1 = en; in1 = v; clr1 = clr;
        @(posedge clk); #1;
        en1 = 1'b0; clr1 = 1'b0;
    endtask

    function automatic exp_t mk(input int d, input logic s);
        exp_t e;
        e.d = 8'(d);
        e.s = s;
        return e;
    endfunction

    // dut0 monitor: compare each accepted head against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && valid0 && rdy0) begin
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d0 unexpected output: got %0d, want none", $signed(data0));
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("d0 data", $signed(data0), $signed(e.d));
                check("d0 sat", {31'd0, sat0}, {31'd0, e.s});
            end
        end
    end

    // dut1 monitor.
    always @(negedge clk) begin
        if (rst_n && valid1 && rdy1) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL d1 unexpected output: got %0d, want none", $signed(data1));
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("d1 data", $signed(data1), $signed(e.d));
                check("d1 sat", {31'd0, sat1}, {31'd0, e.s});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [19:0] vec [9];

        repeat (3) @(posedge clk);
        #1;
        check("reset d0 valid", {31'd0, valid0}, 0);
        check("reset d0 data",  {24'd0, data0},  0);
        check("reset d0 sat",   {31'd0, sat0},   0);
        check("reset d0 ovf",   {31'd0, ovf0},   0);
        check("reset d1 valid", {31'd0, valid1}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Defaults: 2048->1, 6143->1, 6144->2; zeros between are skipped.
        vec = '{20'sd2048, 20'sd0, 20'sd0, 20'sd0, 20'sd6143,
                20'sd0, 20'sd0, 20'sd0, 20'sd6144};
        q0.push_back(mk(1, 1'b0));
        q0.push_back(mk(1, 1'b0));
        q0.push_back(mk(2, 1'b0));
        rdy0 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc0(1'b1, vec[i], 1'b0);
            if (i < 2) check("latency valid low", {31'd0, valid0}, 0);
            if (i == 2) check("latency valid high", {31'd0, valid0}, 1);
        end
        repeat (4) cyc0(1'b0, 20'sd0, 1'b0);

        // Saturation: 524287 rounds to 128 -> clamps to 127. -524288 rounds
        // to exactly -128, inside the range, so it is not flagged.
        cyc0(1'b0, 20'sd0, 1'b1);
        vec = '{20'sh7FFFF, 20'sd0, 20'sd0, 20'sd0, 20'sh80000,
                20'sd0, 20'sd0, 20'sd0, -20'sd2048};
        q0.push_back(mk(127, 1'b1));
        q0.push_back(mk(-128, 1'b0));
        q0.push_back(mk(0, 1'b0));
        for (int i = 0; i < 9; i++) cyc0(1'b1, vec[i], 1'b0);
        repeat (4) cyc0(1'b0, 20'sd0, 1'b0);
`ifdef FIR_DEC_SATCNT_EN
        check("d0 sat_count", {16'd0, sc0}, 1);
`endif

        // dec_clr mid-stream: fill past capacity (ovf), phase left at 2.
        cyc0(1'b0, 20'sd0, 1'b1);
        rdy0 = 1'b0;
        for (int i = 0; i < 22; i++) cyc0(1'b1, 20'(i * 4096), 1'b0);
        repeat (2) cyc0(1'b0, 20'sd0, 1'b0);
        check("pre-clr d0 ovf", {31'd0, ovf0}, 1);
        check("pre-clr d0 valid", {31'd0, valid0}, 1);
        cyc0(1'b1, 20'sd8192, 1'b1);
        check("post-clr d0 valid", {31'd0, valid0}, 0);
        check("post-clr d0 ovf", {31'd0, ovf0}, 0);
        rdy0 = 1'b1;
        q0.push_back(mk(7, 1'b0));
        cyc0(1'b1, 20'sd28672, 1'b0);
        repeat (4) cyc0(1'b0, 20'sd0, 1'b0);

        // dut1 overflow: 6 samples with no consumer -> first 4 kept.
        cyc1(1'b0, 20'sd0, 1'b1);
        rdy1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) q1.push_back(mk(k + 1, 1'b0));
            cyc1(1'b1, 20'((k + 1) * 4096), 1'b0);
            if (k == 4) check("d1 ovf before 5th write", {31'd0, ovf1}, 0);
            if (k == 5) check("d1 ovf after 5th write", {31'd0, ovf1}, 1);
        end
        cyc1(1'b0, 20'sd0, 1'b0);
        rdy1 = 1'b1;
        repeat (6) cyc1(1'b0, 20'sd0, 1'b0);
        check("d1 drained valid", {31'd0, valid1}, 0);

        // dut1 full with simultaneous push and pop.
        cyc1(1'b0, 20'sd0, 1'b1);
        rdy1 = 1'b0;
        for (int k = 1; k <= 12; k++) q1.push_back(mk(k, 1'b0));
        for (int k = 1; k <= 4; k++) cyc1(1'b1, 20'(k * 4096), 1'b0);
        repeat (2) cyc1(1'b0, 20'sd0, 1'b0);
        cyc1(1'b1, 20'(5 * 4096), 1'b0);
        rdy1 = 1'b1;
        for (int k = 6; k <= 12; k++) begin
            cyc1(1'b1, 20'(k * 4096), 1'b0);
            check("d1 full valid", {31'd0, valid1}, 1);
        end
        check("d1 full ovf", {31'd0, ovf1}, 0);
        repeat (8) cyc1(1'b0, 20'sd0, 1'b0);

        // Asynchronous reset while dut1 holds data and ovf is set.
        rdy1 = 1'b0;
        for (int k = 0; k < 6; k++) cyc1(1'b1, 20'((k + 1) * 4096), 1'b0);
        cyc1(1'b0, 20'sd0, 1'b0);
        check("pre-rst d1 valid", {31'd0, valid1}, 1);
        check("pre-rst d1 ovf", {31'd0, ovf1}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst d1 valid", {31'd0, valid1}, 0);
        check("async rst d1 data", {24'd0, data1}, 0);
        check("async rst d1 ovf", {31'd0, ovf1}, 0);
        q1.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // dut0 phase was 1 before reset; the first sample after must be kept.
        rdy0 = 1'b1;
        q0.push_back(mk(9, 1'b0));
        cyc0(1'b1, 20'sd36864, 1'b0);
        repeat (4) cyc0(1'b0, 20'sd0, 1'b0);

        check("d0 scoreboard empty", q0.size(), 0);
        check("d1 scoreboard empty", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
